// File: rtl/imem_loader.sv
// imem_loader: switch-entry writer for the processor's instruction memory.
//
// The operator keys each 16-bit instruction in as two bytes on SwByte, low half first, one
// BytePulse per half. Each completed word is written through a WrReq/WrAck handshake to
// auto-incrementing addresses starting at 0. Busy holds the processor off for the session;
// Done stays high once the session ends, until the next Start or reset.
//
// Ports:
//   CLOCK_50   in   system clock, all state changes on posedge
//   ResetN     in   asynchronous active-low reset
//   Start      in   pulse: begin a load session (from IDLE or DONE only)
//   BytePulse  in   pulse: capture SwByte as the next half-word
//   Finish     in   pulse: end the session early (ignored while a write is pending)
//   SwByte     in   byte value from the switches
//   WrAck      in   memory accepted the write; may come with WrReq or any later cycle
//   WrReq      out  write request, registered
//   WrAddr     out  write address
//   WrData     out  write data {hi, lo}
//   Busy       out  session active
//   Done       out  session complete (level)
//   WordCount  out  words written this session, 0..DEPTH
//   State      out  FSM encoding for the display: IDLE=0 LO=1 HI=2 WR=3 DONE=4
//
// Optional feature, macro IMEM_LOADER_CHECKSUM_EN: adds output Checksum, the mod-2**16 sum of
// every word written this session, cleared on reset and on Start.

module imem_loader #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 16,  // must be 2*8
  parameter int unsigned DEPTH  = 128  // must be 2**ADDR_W
) (
  input  logic              CLOCK_50,
  input  logic              ResetN,
  input  logic              Start,
  input  logic              BytePulse,
  input  logic              Finish,
  input  logic [7:0]        SwByte,
  input  logic              WrAck,
  output logic              WrReq,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [DATA_W-1:0] WrData,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W:0]   WordCount,
  output logic [3:0]        State
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]       Checksum
`endif
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLo   = 3'd1,
    StHi   = 3'd2,
    StWr   = 3'd3,
    StDone = 3'd4
  } state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CountMax = (ADDR_W + 1)'(DEPTH);

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ADDR_W:0]     count_q, count_d;

  always_ff @(posedge CLOCK_50 or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = done_q;
    count_d = count_q;

    unique case (state_q)
      StIdle, StDone: begin
        // Start outranks a coincident BytePulse: the byte is dropped
        if (Start) begin
          addr_d  = '0;
          count_d = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = StLo;
        end
      end
      StLo: begin
        if (Finish) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end else if (BytePulse) begin
          data_d[7:0] = SwByte;
          state_d     = StHi;
        end
      end
      StHi: begin
        // Finish here drops the captured low byte without writing it
        if (Finish) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end else if (BytePulse) begin
          data_d[DATA_W-1 -: 8] = SwByte;
          req_d                 = 1'b1;
          state_d               = StWr;
        end
      end
      StWr: begin
        // Address and data hold until the ack; Finish cannot abort a pending write
        if (WrAck) begin
          req_d = 1'b0;
          if (count_q != CountMax) count_d = count_q + 1'b1;
          if (addr_q == LastAddr) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = StLo;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign WrReq     = req_q;
  assign WrAddr    = addr_q;
  assign WrData    = data_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign WordCount = count_q;
  assign State     = {1'b0, state_q};

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [15:0] csum_q;

  always_ff @(posedge CLOCK_50 or negedge ResetN) begin
    if (!ResetN) begin
      csum_q <= '0;
    end else if ((state_q == StIdle || state_q == StDone) && Start) begin
      csum_q <= '0;
    end else if (state_q == StWr && WrAck) begin
      csum_q <= csum_q + 16'(data_q);
    end
  end

  assign Checksum = csum_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a session-level reference model (active / byte held /
// write pending flags) is compared against every DUT output on each falling edge, with
// directed sequences carrying literal expectations followed by a randomized phase.

module tb_imem_loader;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 128;

  logic              CLOCK_50 = 1'b0;
  logic              ResetN = 1'b1;
  logic              Start = 1'b0;
  logic              BytePulse = 1'b0;
  logic              Finish = 1'b0;
  logic [7:0]        SwByte = '0;
  logic              WrAck = 1'b0;
  logic              WrReq;
  logic [ADDR_W-1:0] WrAddr;
  logic [DATA_W-1:0] WrData;
  logic              Busy;
  logic              Done;
  logic [ADDR_W:0]   WordCount;
  logic [3:0]        State;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [15:0]       Checksum;
`endif

  int n_checks = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  always #5 CLOCK_50 = ~CLOCK_50;

  imem_loader #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .ResetN   (ResetN),
    .Start    (Start),
    .BytePulse(BytePulse),
    .Finish   (Finish),
    .SwByte   (SwByte),
    .WrAck    (WrAck),
    .WrReq    (WrReq),
    .WrAddr   (WrAddr),
    .WrData   (WrData),
    .Busy     (Busy),
    .Done     (Done),
    .WordCount(WordCount),
    .State    (State)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .Checksum (Checksum)
`endif
  );

  // Reference model: session-level view of the loader
  bit          m_active = 1'b0;  // session in progress
  bit          m_held = 1'b0;    // low byte captured, waiting for high byte
  bit          m_pend = 1'b0;    // word complete, waiting for ack
  bit          m_done = 1'b0;
  int          m_addr = 0;
  int          m_count = 0;
  logic [15:0] m_data = '0;
  logic [15:0] m_csum = '0;

  function automatic int m_state();
    if (!m_active) return m_done ? 4 : 0;
    if (m_pend) return 3;
    return m_held ? 2 : 1;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_held   = 1'b0;
    m_pend   = 1'b0;
    m_done   = 1'b0;
    m_addr   = 0;
    m_count  = 0;
    m_data   = '0;
    m_csum   = '0;
  endtask

  task automatic model_step();
    if (!m_active) begin
      if (Start) begin
        m_active = 1'b1;
        m_done   = 1'b0;
        m_held   = 1'b0;
        m_pend   = 1'b0;
        m_addr   = 0;
        m_count  = 0;
        m_csum   = '0;
      end
    end else if (m_pend) begin
      if (WrAck) begin
        m_pend  = 1'b0;
        m_count = m_count + 1;
        m_csum  = m_csum + m_data;
        if (m_addr == DEPTH - 1) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end else begin
          m_addr = m_addr + 1;
        end
      end
    end else if (Finish) begin
      m_active = 1'b0;
      m_done   = 1'b1;
      m_held   = 1'b0;
    end else if (BytePulse) begin
      if (!m_held) begin
        m_data[7:0] = SwByte;
        m_held      = 1'b1;
      end else begin
        m_data[15:8] = SwByte;
        m_held       = 1'b0;
        m_pend       = 1'b1;
      end
    end
  endtask

  always @(posedge CLOCK_50) if (ResetN) model_step();

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (cmp_en) begin
      check("WrReq", 32'(WrReq), 32'(m_pend));
      check("WrAddr", 32'(WrAddr), m_addr);
      check("WrData", 32'(WrData), 32'(m_data));
      check("Busy", 32'(Busy), 32'(m_active));
      check("Done", 32'(Done), 32'(m_done));
      check("WordCount", 32'(WordCount), m_count);
      check("State", 32'(State), m_state());
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (m_done) check("Checksum", 32'(Checksum), 32'(m_csum));
`endif
    end
  end

  // Drive one cycle of inputs from a falling edge, return at the next falling edge
  task automatic step(input bit s, input bit b, input bit f, input bit a, input logic [7:0] sw);
    Start     = s;
    BytePulse = b;
    Finish    = f;
    WrAck     = a;
    SwByte    = sw;
    @(negedge CLOCK_50);
    Start     = 1'b0;
    BytePulse = 1'b0;
    Finish    = 1'b0;
    WrAck     = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 ResetN = 1'b0;
    model_reset();
    repeat (2) @(negedge CLOCK_50);
    cmp_en = 1'b1;
    check("reset_WrReq", 32'(WrReq), 32'd0);
    check("reset_Busy", 32'(Busy), 32'd0);
    check("reset_State", 32'(State), 32'd0);
    check("reset_WordCount", 32'(WordCount), 32'd0);
    ResetN = 1'b1;
    @(negedge CLOCK_50);

    // Start, then one word with ack tied high
    step(1, 0, 0, 0, 8'h00);
    check("start_Busy", 32'(Busy), 32'd1);
    check("start_State", 32'(State), 32'd1);
    check("start_WrAddr", 32'(WrAddr), 32'd0);
    check("start_WrReq", 32'(WrReq), 32'd0);
    check("start_Done", 32'(Done), 32'd0);
    step(0, 1, 0, 1, 8'h34);
    check("lo_State", 32'(State), 32'd2);
    step(0, 1, 0, 1, 8'h12);
    check("w0_WrReq", 32'(WrReq), 32'd1);
    check("w0_WrData", 32'(WrData), 32'h1234);
    check("w0_WrAddr", 32'(WrAddr), 32'd0);
    step(0, 0, 0, 1, 8'h00);
    check("w0_ack_WrReq", 32'(WrReq), 32'd0);
    check("w0_ack_WrAddr", 32'(WrAddr), 32'd1);
    check("w0_ack_WordCount", 32'(WordCount), 32'd1);
    check("w0_ack_State", 32'(State), 32'd1);

    // Delayed ack: request stays stable, single increment
    step(0, 1, 0, 0, 8'h78);
    step(0, 1, 0, 0, 8'h56);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 8'h00);
      check("hold_WrReq", 32'(WrReq), 32'd1);
      check("hold_WrData", 32'(WrData), 32'h5678);
      check("hold_WrAddr", 32'(WrAddr), 32'd1);
      check("hold_WordCount", 32'(WordCount), 32'd1);
    end
    step(0, 0, 1, 1, 8'h00);  // Finish with the ack: ignored, write completes
    check("w1_WordCount", 32'(WordCount), 32'd2);
    check("w1_WrAddr", 32'(WrAddr), 32'd2);
    check("w1_State", 32'(State), 32'd1);

    // Half word then Finish: nothing written
    step(0, 1, 0, 0, 8'hAA);
    step(0, 1, 1, 1, 8'hBB);  // Finish beats BytePulse
    check("fin_Done", 32'(Done), 32'd1);
    check("fin_Busy", 32'(Busy), 32'd0);
    check("fin_WordCount", 32'(WordCount), 32'd2);
    check("fin_State", 32'(State), 32'd4);
    step(0, 1, 0, 1, 8'h11);  // BytePulse in DONE ignored
    check("done_idle_WrReq", 32'(WrReq), 32'd0);

    // Checksum session: 0xFFFF + 0x0002 = 0x0001
    step(1, 1, 0, 0, 8'h55);  // Start beats BytePulse
    check("restart_State", 32'(State), 32'd1);
    check("restart_WordCount", 32'(WordCount), 32'd0);
    step(0, 1, 0, 1, 8'hFF);
    step(0, 1, 0, 1, 8'hFF);
    step(0, 0, 0, 1, 8'h00);
    step(0, 1, 0, 1, 8'h02);
    step(0, 1, 0, 1, 8'h00);
    step(0, 0, 0, 1, 8'h00);
    step(0, 0, 1, 0, 8'h00);
    check("cs_WordCount", 32'(WordCount), 32'd2);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("cs_Checksum", 32'(Checksum), 32'h0001);
`endif

    // Asynchronous reset while a write is pending
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h01);
    step(0, 1, 0, 0, 8'h02);
    check("pre_rst_WrReq", 32'(WrReq), 32'd1);
    #2 ResetN = 1'b0;
    model_reset();
    #1;
    check("async_rst_WrReq", 32'(WrReq), 32'd0);
    check("async_rst_State", 32'(State), 32'd0);
    @(negedge CLOCK_50);
    ResetN = 1'b1;
    @(negedge CLOCK_50);

    // Fill the whole memory
    step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, 0, 1, 8'(i));
      step(0, 1, 0, 1, 8'(~i));
      if (i == DEPTH - 1) begin
        check("full_last_WrAddr", 32'(WrAddr), 32'd127);
        check("full_last_WrReq", 32'(WrReq), 32'd1);
      end
      step(0, 0, 0, 1, 8'h00);
    end
    check("full_State", 32'(State), 32'd4);
    check("full_WordCount", 32'(WordCount), 32'd128);
    check("full_Done", 32'(Done), 32'd1);
    check("full_WrAddr", 32'(WrAddr), 32'd127);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 1, 8'hC3);
      check("full_extra_WrReq", 32'(WrReq), 32'd0);
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 29) == 0), ($urandom_range(0, 2) == 0), 8'($urandom));
    end

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
